peak_detector: RTL and testbench
================================

PEAK_DETECTOR -- requirements
Module: peak_detector

Interface
REQ-001 The block SHALL have parameter DATA_W, default SIZE_FILTER_DATA+1, giving the width of the shaped-filter sample.
REQ-002 The block SHALL have parameter THRESHOLD, default 200 (signed), giving the arming level.
REQ-003 The block SHALL have parameter HYST, default 32 (unsigned, >0), giving the drop below the running maximum that ends a pulse.
REQ-004 The block SHALL have parameter DEAD_TIME, default 16 (>=1), giving the number of post-pulse blanking cycles.
REQ-005 The block SHALL have parameter TS_W, default 32, giving the timestamp width.
REQ-006 Port clk: input, 1 bit, single clock; all logic on its rising edge.
REQ-007 Port reset: input, 1 bit, synchronous, active-high.
REQ-008 Port filter_data: input, DATA_W bits, signed two's-complement trapezoid-filter output, one sample per clk.
REQ-009 Port peak_amp: output, DATA_W bits, signed maximum of the completed pulse.
REQ-010 Port peak_time: output, TS_W bits, timestamp of the sample that held the maximum.
REQ-011 Port peak_valid: output, 1 bit, result available.
REQ-012 Port peak_ready: input, 1 bit, consumer accepts the result.
REQ-013 Port drop_cnt: output, 8 bits, count of results lost to backpressure.
REQ-014 Port busy: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-015 A free-running TS_W-bit counter ts SHALL increment every clk, wrap from all-ones to 0, and be the timestamp of the sample presented in that cycle.
REQ-016 All comparisons SHALL be signed; max-HYST SHALL be computed at DATA_W+1 bits so it never wraps.
REQ-017 The FSM SHALL have states IDLE, TRACK, DEAD and WAIT_LOW, and act on filter_data directly, with no input register.
REQ-018 In IDLE, when filter_data > THRESHOLD, the FSM SHALL move to TRACK and load max=filter_data and tmax=ts.
REQ-019 In TRACK, when filter_data > max, the block SHALL update max and tmax; equal values SHALL NOT update, so the first sample of a plateau is kept.
REQ-020 In TRACK, when filter_data < max-HYST or filter_data <= THRESHOLD, the block SHALL complete the pulse, move to DEAD, and load the dead counter with DEAD_TIME-1.
REQ-021 In DEAD, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to IDLE if filter_data <= THRESHOLD, otherwise to WAIT_LOW.
REQ-022 In WAIT_LOW, the FSM SHALL return to IDLE on the first sample <= THRESHOLD, and that same sample SHALL NOT re-arm.
REQ-023 On completion at edge k, peak_amp, peak_time and peak_valid SHALL be registered so they are visible after edge k, giving a latency of 1 cycle from the terminating sample.
REQ-024 The output SHALL be a single-entry holding register: peak_valid stays high and peak_amp/peak_time stay stable until an edge with peak_valid && peak_ready.
REQ-025 When completion coincides with peak_valid && peak_ready in the same cycle, the new result SHALL be loaded and peak_valid SHALL stay high.
REQ-026 When completion occurs while peak_valid && !peak_ready, the new result SHALL be discarded and drop_cnt SHALL increment, saturating at 255.
REQ-027 Samples in DEAD and WAIT_LOW SHALL be ignored for detection.

Reset
REQ-028 When reset=1 at an edge, the block SHALL set state=IDLE, ts=0, max=0, tmax=0, dead counter=0, peak_amp=0, peak_time=0, peak_valid=0, drop_cnt=0 and busy=0.
REQ-029 Reset SHALL take priority over every other event, including in TRACK and with peak_valid pending; an in-flight pulse SHALL be lost and no result emitted.
REQ-030 In the first cycle after reset deasserts, the block SHALL process filter_data normally, with ts=0.

Verification
REQ-031 Trapezoid 0->500 rising 50/cycle, flat 10 cycles, falling 50/cycle, peak_ready=1 -> one result, peak_amp=500, peak_time=ts of first 500 sample, peak_valid 1 cycle, asserted the cycle after the sample 450.
REQ-032 Pulse reaching 201 then 0 -> peak_amp=201; pulse reaching 200 -> no result, busy stays 0.
REQ-033 peak_ready=0 with two pulses of 300 and 400 separated by 40 cycles -> peak_amp holds 300, drop_cnt=1; raise peak_ready -> peak_valid falls next cycle.
REQ-034 Second pulse starting 5 cycles after the first completion, DEAD_TIME=16, input still above 200 at DEAD end -> WAIT_LOW, no second result until input <= 200 and re-crosses.
REQ-035 reset=1 mid-TRACK with peak_valid=1 -> all outputs 0 next cycle, no result emitted for the interrupted pulse.
REQ-036 ts preloaded near wrap (force 2^TS_W-3) with peak at ts wrap -> peak_time=0; negative input -900 with THRESHOLD=-1000 -> arms, peak_amp signed-correct.

Source files
------------

// File: rtl/peak_detector.sv
// Peak detector for a shaped (trapezoid) filter stream.
// Arms when the sample rises above THRESHOLD and follows the running maximum.
// A pulse ends when the sample drops HYST below that maximum, or falls back to
// THRESHOLD or lower. The block then blanks for DEAD_TIME cycles, and if the
// input is still high it waits for a low sample before it can re-arm.
// Each completed pulse is offered through a single-entry valid/ready holding
// register. A result that cannot be accepted is counted in drop_cnt.
module peak_detector #(
    parameter int          SIZE_FILTER_DATA = 15,
    parameter int          DATA_W           = SIZE_FILTER_DATA + 1,
    parameter int signed   THRESHOLD        = 200,
    parameter int unsigned HYST             = 32,
    parameter int unsigned DEAD_TIME        = 16,
    parameter int          TS_W             = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] filter_data,
    output logic signed [DATA_W-1:0] peak_amp,
    output logic        [TS_W-1:0]   peak_time,
    output logic                     peak_valid,
    input  logic                     peak_ready,
    output logic        [7:0]        drop_cnt,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        DEAD,
        WAIT_LOW
    } state_e;

    localparam int CNT_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [CNT_W-1:0]         DEAD_LOAD = CNT_W'(DEAD_TIME - 1);
    localparam logic signed [DATA_W-1:0] THR_S     = DATA_W'(THRESHOLD);
    localparam logic signed [DATA_W:0]   HYST_S    = (DATA_W + 1)'(HYST);

    state_e                     state_q;
    logic        [TS_W-1:0]     ts_q;
    logic signed [DATA_W-1:0]   max_q;
    logic        [TS_W-1:0]     tmax_q;
    logic        [CNT_W-1:0]    dead_cnt_q;
    logic                       busy_q;
    logic signed [DATA_W-1:0]   amp_q;
    logic        [TS_W-1:0]     time_q;
    logic                       valid_q;
    logic        [7:0]          drop_q;

    // One extra bit of headroom, so max - HYST cannot wrap when max is near the negative limit.
    logic signed [DATA_W:0]     max_ext;
    logic signed [DATA_W:0]     data_ext;
    logic signed [DATA_W:0]     floor_ext;
    logic                       above_thr;
    logic                       below_floor;
    logic                       new_max;
    logic                       complete;
    logic                       can_load;

    assign max_ext     = {max_q[DATA_W-1], max_q};
    assign data_ext    = {filter_data[DATA_W-1], filter_data};
    assign floor_ext   = max_ext - HYST_S;
    assign above_thr   = filter_data > THR_S;
    assign below_floor = data_ext < floor_ext;
    assign new_max     = filter_data > max_q;
    assign complete    = (state_q == TRACK) && (below_floor || !above_thr);
    assign can_load    = !valid_q || peak_ready;

    // Free-running timestamp; it wraps naturally and labels the sample of the current cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= only, so every block reads pre-edge values.
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Pulse FSM: arm, track the maximum, blank, then wait for the input to go low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            max_q      <= '0;
            tmax_q     <= '0;
            dead_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (above_thr) begin
                        state_q <= TRACK;
                        max_q   <= filter_data;
                        tmax_q  <= ts_q;
                        busy_q  <= 1'b1;
                    end
                end
                TRACK: begin
                    if (complete) begin
                        state_q    <= DEAD;
                        dead_cnt_q <= DEAD_LOAD;
                    end else if (new_max) begin
                        // Strictly greater only, so a plateau keeps the time of its first sample.
                        max_q  <= filter_data;
                        tmax_q <= ts_q;
                    end
                end
                DEAD: begin
                    if (dead_cnt_q == '0) begin
                        if (above_thr) begin
                            state_q <= WAIT_LOW;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        dead_cnt_q <= dead_cnt_q - CNT_W'(1);
                    end
                end
                WAIT_LOW: begin
                    // The low sample that ends this state is not used for arming.
                    if (!above_thr) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry result holding register with drop counting under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            amp_q   <= '0;
            time_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else if (complete) begin
            if (can_load) begin
                amp_q   <= max_q;
                time_q  <= tmax_q;
                valid_q <= 1'b1;
            end else if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end else if (valid_q && peak_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign peak_amp   = amp_q;
    assign peak_time  = time_q;
    assign peak_valid = valid_q;
    assign drop_cnt   = drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_peak_detector.sv
// Scoreboard bench for peak_detector.
// Instance A uses the default levels (threshold 200, 32-bit timestamp).
// Instance B uses threshold -1000 and a 5-bit timestamp, so the timestamp wraps often.
// A behavioural model predicts each accepted result and pushes it into a queue.
// Monitors on the falling edge pop the queue and compare it with the DUT outputs.
module tb_peak_detector;

    localparam int DW = 16;

    typedef struct {
        int     phase;      // 0 quiet, 1 in pulse, 2 blanking, 3 waiting for low
        int     mx;
        longint tmax;
        int     dead_left;
        longint ts;
        bit     valid;
        int     amp;
        longint ptime;
        int     drop;
    } mdl_t;

    typedef struct {
        int     amp;
        longint ptime;
    } res_t;

    logic clk;
    logic a_reset, a_ready, a_valid, a_busy;
    logic signed [DW-1:0] a_fd, a_amp;
    logic [31:0] a_time;
    logic [7:0]  a_drop;
    logic b_reset, b_ready, b_valid, b_busy;
    logic signed [DW-1:0] b_fd, b_amp;
    logic [4:0]  b_time;
    logic [7:0]  b_drop;

    int   checks = 0;
    int   failures = 0;
    mdl_t ma, mb;
    res_t exp_a[$];
    res_t exp_b[$];

    peak_detector #(.THRESHOLD(200), .HYST(32), .DEAD_TIME(16), .TS_W(32)) dut_a (
        .clk(clk), .reset(a_reset), .filter_data(a_fd), .peak_amp(a_amp),
        .peak_time(a_time), .peak_valid(a_valid), .peak_ready(a_ready),
        .drop_cnt(a_drop), .busy(a_busy));

    peak_detector #(.THRESHOLD(-1000), .HYST(32), .DEAD_TIME(4), .TS_W(5)) dut_b (
        .clk(clk), .reset(b_reset), .filter_data(b_fd), .peak_amp(b_amp),
        .peak_time(b_time), .peak_valid(b_valid), .peak_ready(b_ready),
        .drop_cnt(b_drop), .busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge, written from the pulse rules.
    function automatic void mdl_step(inout mdl_t m, input bit rst, input int x, input bit rdy,
                                     input int thr, input int hyst, input int dead,
                                     input int ts_w, output bit loaded);
        bit done;
        loaded = 1'b0;
        done   = 1'b0;
        if (rst) begin
            m = '{default: 0};
            return;
        end
        if (m.phase == 0) begin
            if (x > thr) begin
                m.phase = 1;
                m.mx    = x;
                m.tmax  = m.ts;
            end
        end else if (m.phase == 1) begin
            if (x < m.mx - hyst || x <= thr) begin
                done        = 1'b1;
                m.phase     = 2;
                m.dead_left = dead;
            end else if (x > m.mx) begin
                m.mx   = x;
                m.tmax = m.ts;
            end
        end else if (m.phase == 2) begin
            m.dead_left--;
            if (m.dead_left == 0) m.phase = (x <= thr) ? 0 : 3;
        end else begin
            if (x <= thr) m.phase = 0;
        end
        if (done) begin
            if (!m.valid || rdy) begin
                m.valid = 1'b1;
                m.amp   = m.mx;
                m.ptime = m.tmax;
                loaded  = 1'b1;
            end else if (m.drop < 255) begin
                m.drop++;
            end
        end else if (m.valid && rdy) begin
            m.valid = 1'b0;
        end
        m.ts = (m.ts + 1) & ((longint'(1) << ts_w) - 1);
    endfunction

    // Advance one edge and let both models consume the inputs that were applied.
    task automatic tick();
        bit ld;
        @(posedge clk);
        #1;
        mdl_step(ma, a_reset, int'(a_fd), a_ready, 200, 32, 16, 32, ld);
        if (a_reset) exp_a.delete();
        else if (ld) exp_a.push_back(res_t'{ma.amp, ma.ptime});
        mdl_step(mb, b_reset, int'(b_fd), b_ready, -1000, 32, 4, 5, ld);
        if (b_reset) exp_b.delete();
        else if (ld) exp_b.push_back(res_t'{mb.amp, mb.ptime});
    endtask

    task automatic send_a(input int x, input bit rdy);
        a_fd    = DW'(x);
        a_ready = rdy;
        tick();
    endtask

    task automatic send_b(input int x, input bit rdy);
        b_fd    = DW'(x);
        b_ready = rdy;
        tick();
    endtask

    // Monitor A: compare against the model's handshake state and the head of the queue.
    always @(negedge clk) begin
        if (!a_reset) begin
            check("a_valid", a_valid, ma.valid);
            check("a_busy", a_busy, (ma.phase != 0));
            check("a_drop", a_drop, ma.drop);
            if (a_valid === 1'b1) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_result: got amp %0d, want no result", a_amp);
                end else begin
                    check("a_amp", a_amp, exp_a[0].amp);
                    check("a_time", {32'd0, a_time}, exp_a[0].ptime);
                    if (a_ready) void'(exp_a.pop_front());
                end
            end
        end
    end

    // Monitor B: same comparisons for the negative-threshold, short-timestamp instance.
    always @(negedge clk) begin
        if (!b_reset) begin
            check("b_valid", b_valid, mb.valid);
            check("b_busy", b_busy, (mb.phase != 0));
            check("b_drop", b_drop, mb.drop);
            if (b_valid === 1'b1) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_result: got amp %0d, want no result", b_amp);
                end else begin
                    check("b_amp", b_amp, exp_b[0].amp);
                    check("b_time", {59'd0, b_time}, exp_b[0].ptime);
                    if (b_ready) void'(exp_b.pop_front());
                end
            end
        end
    end

    initial begin
        a_reset = 1'b1; a_fd = '0; a_ready = 1'b1;
        b_reset = 1'b1; b_fd = -16'sd2000; b_ready = 1'b1;
        repeat (3) tick();
        check("a_rst_amp", a_amp, 0);
        check("a_rst_time", {32'd0, a_time}, 0);
        check("a_rst_valid", a_valid, 0);
        check("a_rst_busy", a_busy, 0);
        check("a_rst_drop", a_drop, 0);
        check("b_rst_amp", b_amp, 0);
        check("b_rst_valid", b_valid, 0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Trapezoid to 500 with a 10-cycle flat top.
        for (int v = 0; v <= 500; v += 50) send_a(v, 1'b1);
        repeat (10) send_a(500, 1'b1);
        for (int v = 450; v >= 0; v -= 50) send_a(v, 1'b1);
        repeat (30) send_a(0, 1'b1);

        // Just above and exactly at the threshold.
        send_a(201, 1'b1);
        send_a(0, 1'b1);
        repeat (30) send_a(0, 1'b1);
        send_a(200, 1'b1);
        repeat (30) send_a(0, 1'b1);

        // Two pulses under backpressure: the first result is held and the second is dropped.
        send_a(100, 1'b0); send_a(200, 1'b0); send_a(300, 1'b0); send_a(100, 1'b0);
        repeat (40) send_a(0, 1'b0);
        send_a(200, 1'b0); send_a(400, 1'b0); send_a(100, 1'b0);
        repeat (20) send_a(0, 1'b0);
        repeat (5) send_a(0, 1'b1);

        // A second pulse starts during blanking and is still high when blanking ends.
        send_a(100, 1'b1); send_a(300, 1'b1); send_a(250, 1'b1);
        repeat (5) send_a(100, 1'b1);
        repeat (20) send_a(400, 1'b1);
        send_a(100, 1'b1);
        send_a(300, 1'b1); send_a(100, 1'b1);
        repeat (25) send_a(0, 1'b1);

        // Reset in the middle of a pulse while a result is pending.
        send_a(300, 1'b0); send_a(0, 1'b0);
        repeat (20) send_a(0, 1'b0);
        send_a(300, 1'b0); send_a(400, 1'b0);
        a_reset = 1'b1;
        send_a(450, 1'b0);
        check("a_midrst_valid", a_valid, 0);
        check("a_midrst_amp", a_amp, 0);
        check("a_midrst_time", {32'd0, a_time}, 0);
        check("a_midrst_busy", a_busy, 0);
        check("a_midrst_drop", a_drop, 0);
        a_reset = 1'b0;
        send_a(100, 1'b1);
        repeat (25) send_a(0, 1'b1);

        // Random pulses with random shapes, gaps and backpressure.
        for (int p = 0; p < 60; p++) begin
            int peak, up, dn, v, flat, gap;
            bit hold;
            peak = $urandom_range(150, 3000);
            up   = $urandom_range(20, 400);
            dn   = $urandom_range(5, 400);
            flat = $urandom_range(0, 4);
            gap  = $urandom_range(0, 25);
            hold = ($urandom_range(0, 4) == 0);
            for (v = 0; v < peak; v += up) send_a(v, hold ? 1'b0 : ($urandom_range(0, 3) != 0));
            repeat (flat + 1) send_a(peak, hold ? 1'b0 : ($urandom_range(0, 3) != 0));
            for (v = peak - dn; v > 0; v -= dn) send_a(v, hold ? 1'b0 : ($urandom_range(0, 3) != 0));
            repeat (gap) send_a($urandom_range(0, 150), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 300; i++) send_a(int'($urandom_range(0, 700)) - 200, ($urandom_range(0, 2) != 0));
        repeat (30) send_a(0, 1'b1);

        // Negative threshold: a -900 sample arms and becomes the peak.
        repeat (3) send_b(-2000, 1'b1);
        send_b(-1500, 1'b1); send_b(-1200, 1'b1); send_b(-900, 1'b1);
        send_b(-950, 1'b1); send_b(-2000, 1'b1);
        repeat (10) send_b(-2000, 1'b1);

        // Place the peak on the sample whose 5-bit timestamp wraps to 0.
        for (int i = 0; i < 64; i++) begin
            if (mb.ts == 30) break;
            send_b(-2000, 1'b1);
        end
        send_b(-1500, 1'b1); send_b(-1200, 1'b1); send_b(-800, 1'b1); send_b(-2000, 1'b1);
        repeat (10) send_b(-2000, 1'b1);

        for (int i = 0; i < 400; i++) send_b(int'($urandom_range(0, 1700)) - 2200, ($urandom_range(0, 3) != 0));

        // Drain everything that is still pending.
        a_fd = '0; b_fd = -16'sd2000;
        repeat (40) send_a(0, 1'b1);
        b_ready = 1'b1;
        repeat (10) tick();
        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
